// File: rtl/spi_controller.sv
// SPI initiator: turns a one-cycle start request into a single {wr, addr, data} register frame
// on spi_cs_n/spi_clk/spi_mosi, returning read data sampled from spi_miso.
module spi_controller #(
    parameter int ADDR_W  = 4,
    parameter int REG_W   = 8,
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              ena,
    input  logic [1:0]        mode,
    input  logic              start,
    input  logic              wr_rdn,
    input  logic [ADDR_W-1:0] addr,
    input  logic [REG_W-1:0]  wdata,
    output logic [REG_W-1:0]  rdata,
    output logic              busy,
    output logic              done,
    output logic              spi_cs_n,
    output logic              spi_clk,
    output logic              spi_mosi,
    input  logic              spi_miso
);

    localparam int FRAME_W = 8 + REG_W;
    localparam int CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W   = $clog2(FRAME_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic               phase_q, phase_d;
    logic [FRAME_W-1:0] tx_q, tx_d;
    logic [REG_W-1:0]   rx_q, rx_d;
    logic               wr_q, wr_d;
    logic               cpol_q, cpol_d;
    logic               cpha_q, cpha_d;
    logic [REG_W-1:0]   rdata_q, rdata_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               cs_n_q, cs_n_d;
    logic               sclk_q, sclk_d;
    logic               mosi_q, mosi_d;

    logic [REG_W-1:0]   data_field;
    logic [FRAME_W-1:0] frame;
    logic               half_end;
    logic               toggle;
    logic               sample;

    always_comb begin
        data_field = wr_rdn ? wdata : {REG_W{1'b0}};
        frame      = {wr_rdn, 7'(addr), data_field};
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        phase_d   = phase_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        wr_d      = wr_q;
        cpol_d    = cpol_q;
        cpha_d    = cpha_q;
        rdata_d   = rdata_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        cs_n_d    = cs_n_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        toggle    = 1'b0;
        sample    = 1'b0;
        half_end  = (cnt_q == CNT_LAST);

        if (state_q != IDLE) begin
            cnt_d = half_end ? '0 : cnt_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                cnt_d  = '0;
                cs_n_d = 1'b1;
                sclk_d = cpol_q;
                // The done cycle itself counts as the mandatory idle cycle between frames.
                if (start && ena && !done_q) begin
                    state_d   = SETUP;
                    busy_d    = 1'b1;
                    cs_n_d    = 1'b0;
                    wr_d      = wr_rdn;
                    cpol_d    = mode[1];
                    cpha_d    = mode[0];
                    sclk_d    = mode[1];
                    bit_cnt_d = '0;
                    phase_d   = 1'b0;
                    rx_d      = '0;
                    tx_d      = mode[0] ? frame : (frame << 1);
                    mosi_d    = mode[0] ? mosi_q : frame[FRAME_W-1];
                end
            end
            SETUP: begin
                if (half_end) begin
                    state_d = SHIFT;
                    toggle  = 1'b1;
                end
            end
            SHIFT: begin
                if (half_end) begin
                    if (bit_cnt_q == BIT_LAST && !phase_q) begin
                        state_d = HOLD;
                    end else begin
                        toggle = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (half_end) begin
                    state_d = GAP;
                    cs_n_d  = 1'b1;
                end
            end
            GAP: begin
                if (half_end) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    if (!wr_q) begin
                        rdata_d = rx_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // phase_q low means the next toggle is a leading edge; CPHA picks which edge samples.
        if (toggle) begin
            sclk_d  = ~sclk_q;
            phase_d = ~phase_q;
            sample  = (~phase_q) ^ cpha_q;
            if (sample) begin
                rx_d      = REG_W'({rx_q, spi_miso});
                bit_cnt_d = bit_cnt_q + BIT_W'(1);
            end else if (bit_cnt_q != BIT_LAST) begin
                mosi_d = tx_q[FRAME_W-1];
                tx_d   = tx_q << 1;
            end
        end

        if (state_q != IDLE && !ena) begin
            state_d = IDLE;
            cnt_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            cs_n_d  = 1'b1;
            sclk_d  = cpol_q;
            rdata_d = rdata_q;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            phase_q   <= 1'b0;
            tx_q      <= '0;
            rx_q      <= '0;
            wr_q      <= 1'b0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            rdata_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            phase_q   <= phase_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            wr_q      <= wr_d;
            cpol_q    <= cpol_d;
            cpha_q    <= cpha_d;
            rdata_q   <= rdata_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            cs_n_q    <= cs_n_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
        end
    end

    assign rdata    = rdata_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign spi_cs_n = cs_n_q;
    assign spi_clk  = sclk_q;
    assign spi_mosi = mosi_q;

endmodule

// File: tb/tb_spi_controller.sv
// Scoreboard bench for spi_controller: a behavioural SPI target captures MOSI and serves MISO,
// expected frames/read data/latency are queued at issue and checked when done pulses.
module tb_spi_controller;

    localparam int ADDR_W  = 4;
    localparam int REG_W   = 8;
    localparam int CLK_DIV = 2;
    localparam int FRAME_W = 8 + REG_W;
    localparam int LATENCY = (2 * FRAME_W + 3) * CLK_DIV;

    logic              clk = 1'b0;
    logic              rstb;
    logic              ena;
    logic [1:0]        mode;
    logic              start;
    logic              wr_rdn;
    logic [ADDR_W-1:0] addr;
    logic [REG_W-1:0]  wdata;
    logic [REG_W-1:0]  rdata;
    logic              busy;
    logic              done;
    logic              spi_cs_n;
    logic              spi_clk;
    logic              spi_mosi;
    logic              spi_miso = 1'b0;

    typedef struct {
        logic [FRAME_W-1:0] frame;
        logic [REG_W-1:0]   rdata;
        int                 accept_cyc;
        logic               cpol;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [REG_W-1:0] model_rdata = '0;

    // Target-side model state.
    logic               s_cpol = 1'b0;
    logic               s_cpha = 1'b0;
    logic [REG_W-1:0]   s_word = '0;
    logic               s_active = 1'b0;
    logic               s_prev_sclk = 1'b0;
    logic               s_prev_mosi = 1'b0;
    logic [FRAME_W-1:0] s_sr = '0;
    logic [FRAME_W-1:0] s_cap = '0;
    int                 s_samples = 0;
    int                 s_viol = 0;
    logic               edge_now;
    logic               sample_now;

    spi_controller #(.ADDR_W(ADDR_W), .REG_W(REG_W), .CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .rstb(rstb), .ena(ena), .mode(mode), .start(start),
        .wr_rdn(wr_rdn), .addr(addr), .wdata(wdata), .rdata(rdata),
        .busy(busy), .done(done), .spi_cs_n(spi_cs_n), .spi_clk(spi_clk),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, actual, expected, $time);
        end
    endtask

    // Frame = write flag at the top, 7-bit address below it, data (zero for reads) in the low bits.
    function automatic logic [FRAME_W-1:0] build_frame(input bit wr, input logic [ADDR_W-1:0] a,
                                                       input logic [REG_W-1:0] d);
        longint v;
        v = (longint'(wr) << (FRAME_W - 1)) + (longint'(a) << REG_W) + (wr ? longint'(d) : 64'd0);
        return v[FRAME_W-1:0];
    endfunction

    // Target model and done monitor, both looking at settled outputs 1 ns after each clk edge.
    always @(posedge clk) begin
        #1;
        if (rstb) begin
            if (spi_cs_n) begin
                s_active = 1'b0;
            end else if (!s_active) begin
                s_active    = 1'b1;
                s_sr        = FRAME_W'(s_word);
                s_cap       = '0;
                s_samples   = 0;
                s_viol      = 0;
                s_prev_sclk = spi_clk;
                s_prev_mosi = spi_mosi;
                if (!s_cpha) begin
                    spi_miso = s_sr[FRAME_W-1];
                    s_sr     = s_sr << 1;
                end
            end else begin
                edge_now   = (spi_clk != s_prev_sclk);
                sample_now = edge_now && ((spi_clk != s_cpol) ^ s_cpha);
                if (spi_mosi != s_prev_mosi && !(edge_now && !sample_now)) s_viol++;
                if (sample_now) begin
                    s_cap = {s_cap[FRAME_W-2:0], spi_mosi};
                    s_samples++;
                end else if (edge_now) begin
                    spi_miso = s_sr[FRAME_W-1];
                    s_sr     = s_sr << 1;
                end
                s_prev_sclk = spi_clk;
                s_prev_mosi = spi_mosi;
            end

            if (done) begin
                checkOutput("done_was_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    checkOutput("mosi_frame", 32'(s_cap), 32'(mon_e.frame));
                    checkOutput("rdata", 32'(rdata), 32'(mon_e.rdata));
                    checkOutput("done_latency", 32'(cyc - mon_e.accept_cyc), 32'(LATENCY));
                    checkOutput("idle_sclk", 32'(spi_clk), 32'(mon_e.cpol));
                    checkOutput("busy_at_done", 32'(busy), 32'd0);
                    checkOutput("cs_n_at_done", 32'(spi_cs_n), 32'd1);
                    checkOutput("mosi_on_sample_edge", 32'(s_viol), 32'd0);
                end
            end
        end
    end

    task automatic applyStimulus(input logic [1:0] m, input bit wr, input logic [ADDR_W-1:0] a,
                                 input logic [REG_W-1:0] d, input logic [REG_W-1:0] miso_word,
                                 input bit in_done_cycle, input bit spam);
        exp_t e;
        int   hold;
        int   waited;
        if (!in_done_cycle) @(negedge clk);
        hold         = in_done_cycle ? 2 : 1;
        s_cpol       = m[1];
        s_cpha       = m[0];
        s_word       = miso_word;
        e.frame      = build_frame(wr, a, d);
        e.rdata      = wr ? model_rdata : miso_word;
        e.accept_cyc = cyc + hold;
        e.cpol       = m[1];
        model_rdata  = e.rdata;
        sb.push_back(e);
        mode   = m;
        wr_rdn = wr;
        addr   = a;
        wdata  = d;
        start  = 1'b1;
        repeat (hold) @(negedge clk);
        waited = 0;
        while (sb.size() != 0 && waited < 4 * LATENCY) begin
            start  = spam;
            mode   = 2'($urandom);
            wr_rdn = 1'($urandom);
            addr   = ADDR_W'($urandom);
            wdata  = REG_W'($urandom);
            @(negedge clk);
            waited++;
        end
        start = 1'b0;
        checkOutput("txn_completed", 32'(sb.size() == 0), 32'd1);
        if (sb.size() != 0) sb.delete();
    endtask

    task automatic waitSamples(input int n);
        int waited;
        waited = 0;
        while (s_samples < n && waited < 4 * LATENCY) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("reached_sample_count", 32'(s_samples >= n), 32'd1);
    endtask

    initial begin
        #(1_000_000);
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rstb   = 1'b0;
        ena    = 1'b1;
        start  = 1'b0;
        mode   = 2'd0;
        wr_rdn = 1'b0;
        addr   = '0;
        wdata  = '0;
        #12;
        checkOutput("reset_rdata", 32'(rdata), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_cs_n", 32'(spi_cs_n), 32'd1);
        checkOutput("reset_sclk", 32'(spi_clk), 32'd0);
        checkOutput("reset_mosi", 32'(spi_mosi), 32'd0);
        @(negedge clk);
        rstb = 1'b1;

        $display("[TB] directed mode 0 write, mode 3/1/2 reads");
        applyStimulus(2'd0, 1'b1, 4'd3, 8'hA5, 8'h00, 1'b0, 1'b0);
        applyStimulus(2'd3, 1'b0, 4'd9, 8'hFF, 8'h5C, 1'b0, 1'b0);
        applyStimulus(2'd1, 1'b0, 4'd6, 8'h12, 8'h3C, 1'b0, 1'b0);
        applyStimulus(2'd2, 1'b0, 4'd15, 8'h34, 8'h3C, 1'b0, 1'b0);

        $display("[TB] start held every cycle while busy");
        applyStimulus(2'd1, 1'b1, 4'd10, 8'h69, 8'h00, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        checkOutput("no_requeued_frame", 32'(busy), 32'd0);

        $display("[TB] start in the done cycle, accepted one cycle later");
        applyStimulus(2'd0, 1'b0, 4'd1, 8'h00, 8'hC3, 1'b0, 1'b0);
        applyStimulus(2'd2, 1'b1, 4'd2, 8'h81, 8'h00, 1'b1, 1'b0);

        $display("[TB] start with ena low is ignored");
        @(negedge clk);
        ena   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ena   = 1'b1;
        @(negedge clk);
        checkOutput("ena_low_no_accept", 32'(busy), 32'd0);
        checkOutput("ena_low_cs_n", 32'(spi_cs_n), 32'd1);

        $display("[TB] ena dropped at SHIFT bit 5");
        s_cpol = 1'b0; s_cpha = 1'b0; s_word = 8'hE7;
        mode = 2'd0; wr_rdn = 1'b0; addr = 4'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitSamples(5);
        ena = 1'b0;
        @(negedge clk);
        checkOutput("abort_cs_n", 32'(spi_cs_n), 32'd1);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_sclk", 32'(spi_clk), 32'd0);
        ena = 1'b1;
        repeat (LATENCY + 10) @(negedge clk);
        checkOutput("abort_rdata_held", 32'(rdata), 32'(model_rdata));
        checkOutput("abort_still_idle", 32'(busy), 32'd0);

        $display("[TB] randomized transactions");
        for (int i = 0; i < 12; i++) begin
            applyStimulus(2'($urandom), 1'($urandom), ADDR_W'($urandom), REG_W'($urandom),
                          REG_W'($urandom), (i % 3) == 2, 1'b0);
        end

        $display("[TB] async reset mid-SHIFT");
        applyStimulus(2'd0, 1'b0, 4'd4, 8'h00, 8'h96, 1'b0, 1'b0);
        @(negedge clk);
        s_cpol = 1'b1; s_cpha = 1'b1; s_word = 8'h99;
        mode = 2'd3; wr_rdn = 1'b0; addr = 4'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitSamples(7);
        #2;
        rstb = 1'b0;
        #1;
        checkOutput("midreset_rdata", 32'(rdata), 32'd0);
        checkOutput("midreset_busy", 32'(busy), 32'd0);
        checkOutput("midreset_done", 32'(done), 32'd0);
        checkOutput("midreset_cs_n", 32'(spi_cs_n), 32'd1);
        checkOutput("midreset_sclk", 32'(spi_clk), 32'd0);
        checkOutput("midreset_mosi", 32'(spi_mosi), 32'd0);
        sb.delete();
        model_rdata = '0;
        @(negedge clk);
        rstb = 1'b1;
        applyStimulus(2'd0, 1'b1, 4'd7, 8'h5A, 8'h00, 1'b0, 1'b0);
        applyStimulus(2'd1, 1'b0, 4'd8, 8'h00, 8'hB4, 1'b0, 1'b0);

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
